// File: rtl/reg_ctrl_sequencer_pkg.sv
// Shared constants for the register-file control sequencer: field positions,
// opcodes, FSM states and the opcode classifier.
package reg_ctrl_sequencer_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ADDR_WIDTH  = 3;
    localparam int DEF_INSTR_WIDTH = 16;
    localparam int DEF_PC_WIDTH    = 8;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LDI     = 3'd2,
        CLS_JMP     = 3'd3,
        CLS_BZ      = 3'd4,
        CLS_HALT    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    function automatic op_class_t classify(input logic [3:0] opc);
        op_class_t cls;
        case (opc)
            OP_NOP:                                        cls = CLS_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: cls = CLS_ALU;
            OP_LDI:                                        cls = CLS_LDI;
            OP_JMP:                                        cls = CLS_JMP;
            OP_BZ:                                         cls = CLS_BZ;
            OP_HALT:                                       cls = CLS_HALT;
            default:                                       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/reg_ctrl_sequencer_decode.sv
// Combinational instruction field decoder: splits an instruction word into
// its opcode class and register/immediate fields.
module ctrl_field_decode
    import reg_ctrl_sequencer_pkg::*;
(
    input  logic [DEF_INSTR_WIDTH-1:0] ir,
    output op_class_t                  op_class,
    output logic [3:0]                 opcode,
    output logic [DEF_ADDR_WIDTH-1:0]  rd,
    output logic [DEF_ADDR_WIDTH-1:0]  rs1,
    output logic [DEF_ADDR_WIDTH-1:0]  rs2,
    output logic [DEF_DATA_WIDTH-1:0]  imm8,
    output logic                       illegal
);

    assign opcode   = ir[OPC_MSB:OPC_LSB];
    assign rd       = ir[RD_MSB:RD_LSB];
    assign rs1      = ir[RS1_MSB:RS1_LSB];
    assign rs2      = ir[RS2_MSB:RS2_LSB];
    assign imm8     = ir[IMM_MSB:IMM_LSB];
    assign op_class = classify(opcode);
    assign illegal  = (op_class == CLS_ILLEGAL);

endmodule

// File: rtl/reg_ctrl_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback sequencer driving an 8-entry
// register file with one-cycle registered read latency.
module reg_ctrl_sequencer
    import reg_ctrl_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int PC_WIDTH    = DEF_PC_WIDTH
)
(
    input  logic                   Clk,
    input  logic                   Reset,
    output logic                   Fetch_Req,
    input  logic                   Instr_Valid,
    input  logic [INSTR_WIDTH-1:0] Instr_In,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [ADDR_WIDTH-1:0]  Source_Reg1,
    output logic [ADDR_WIDTH-1:0]  Source_Reg2,
    output logic [ADDR_WIDTH-1:0]  Dest_Reg,
    output logic                   Reg_Load,
    output logic [3:0]             ALU_Op,
    input  logic                   ALU_Zero,
    output logic                   Imm_Sel,
    output logic [DATA_WIDTH-1:0]  Imm_Out,
    output logic                   Halted,
    output logic                   Illegal_Op
);

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   z_q, z_d;
    logic                   fetch_req_q, fetch_req_d;
    logic [ADDR_WIDTH-1:0]  src1_q, src1_d;
    logic [ADDR_WIDTH-1:0]  src2_q, src2_d;
    logic [ADDR_WIDTH-1:0]  dest_q, dest_d;
    logic                   reg_load_q, reg_load_d;
    logic [3:0]             alu_op_q, alu_op_d;
    logic                   imm_sel_q, imm_sel_d;
    logic [DATA_WIDTH-1:0]  imm_out_q, imm_out_d;
    logic                   halted_q, halted_d;
    logic                   illegal_q, illegal_d;

    logic                   accept;
    op_class_t              dec_class;
    logic [3:0]             dec_opcode;
    logic [ADDR_WIDTH-1:0]  dec_rd, dec_rs1, dec_rs2;
    logic [DATA_WIDTH-1:0]  dec_imm;
    logic                   dec_illegal;

    // A word is only taken while the request is actually being presented.
    assign accept = (state_q == ST_FETCH) && fetch_req_q && Instr_Valid;

    always_comb begin
        ir_d = ir_q;
        if (accept) begin
            ir_d = Instr_In;
        end
    end

    // Decoding the next IR lets outputs settle in the same cycle the state is entered.
    ctrl_field_decode u_decode (
        .ir       (ir_d),
        .op_class (dec_class),
        .opcode   (dec_opcode),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .imm8     (dec_imm),
        .illegal  (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        z_d     = z_q;
        case (state_q)
            ST_FETCH: begin
                if (accept) begin
                    pc_d    = pc_q + PC_WIDTH'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_class)
                    CLS_ALU:  state_d = ST_EXEC;
                    CLS_LDI:  state_d = ST_WB;
                    CLS_JMP: begin
                        pc_d    = dec_imm;
                        state_d = ST_FETCH;
                    end
                    CLS_BZ: begin
                        if (z_q) begin
                            pc_d = dec_imm;
                        end
                        state_d = ST_FETCH;
                    end
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_EXEC: begin
                z_d     = ALU_Zero;
                state_d = ST_WB;
            end
            ST_WB:   state_d = ST_FETCH;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        fetch_req_d = (state_d == ST_FETCH);
        src1_d      = dec_rs1;
        src2_d      = dec_rs2;
        dest_d      = (state_d == ST_WB) ? dec_rd : '0;
        reg_load_d  = (state_d == ST_WB);
        alu_op_d    = (state_d == ST_EXEC) ? dec_opcode : 4'h0;
        imm_sel_d   = (state_d == ST_WB) && (dec_class == CLS_LDI);
        imm_out_d   = dec_imm;
        halted_d    = (state_d == ST_HALT);
        illegal_d   = (state_d == ST_DECODE) && dec_illegal;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            z_q         <= 1'b0;
            fetch_req_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            reg_load_q  <= 1'b0;
            alu_op_q    <= 4'h0;
            imm_sel_q   <= 1'b0;
            imm_out_q   <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            fetch_req_q <= fetch_req_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            dest_q      <= dest_d;
            reg_load_q  <= reg_load_d;
            alu_op_q    <= alu_op_d;
            imm_sel_q   <= imm_sel_d;
            imm_out_q   <= imm_out_d;
            halted_q    <= halted_d;
            illegal_q   <= illegal_d;
        end
    end

    assign Fetch_Req   = fetch_req_q;
    assign PC          = pc_q;
    assign Source_Reg1 = src1_q;
    assign Source_Reg2 = src2_q;
    assign Dest_Reg    = dest_q;
    assign Reg_Load    = reg_load_q;
    assign ALU_Op      = alu_op_q;
    assign Imm_Sel     = imm_sel_q;
    assign Imm_Out     = imm_out_q;
    assign Halted      = halted_q;
    assign Illegal_Op  = illegal_q;

endmodule
